// File: rtl/rs_encode_pkg.sv
// Shared types and helpers for the RS encode line dispatcher.
package rs_encode_pkg;

  typedef enum logic [0:0] {DISP_FEED = 1'b0, DISP_PAD = 1'b1} disp_state_e;

  // Round-robin successor with wrap at any n >= 1.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_w(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/rs_encode_rr_ptr.sv
// Wrapping round-robin pointer over N slots with an advance strobe.
module rs_encode_rr_ptr
  import rs_encode_pkg::*;
#(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_adv,
  output logic [W-1:0] o_ptr
);

  logic [W-1:0] r_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (i_adv) begin
      r_ptr <= W'(rr_next(32'(r_ptr), N));
    end
  end

  assign o_ptr = r_ptr;

endmodule

// File: rtl/rs_encode_line_dispatch.sv
// Splits a line stream into RS blocks, deals them round-robin to encoder units
// and collects them back in order. RS_DISPATCH_STATS_EN adds retire/pad counters.
module rs_encode_line_dispatch
  import rs_encode_pkg::*;
#(
  parameter int unsigned DATA_W       = 512,
  parameter int unsigned NUM_LINES    = 4,
  parameter int unsigned PARITY_W     = 256,
  parameter int unsigned NUM_RS_UNITS = 3
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             src_disp_line_val,
  input  logic [DATA_W-1:0]                src_disp_line,
  input  logic                             src_disp_line_last,
  output logic                             disp_src_line_rdy,
  output logic [NUM_RS_UNITS-1:0]          disp_unit_line_vals,
  output logic [DATA_W-1:0]                disp_unit_line,
  input  logic [NUM_RS_UNITS-1:0]          unit_disp_line_rdys,
  input  logic [NUM_RS_UNITS-1:0]          unit_disp_line_vals,
  input  logic [NUM_RS_UNITS*DATA_W-1:0]   unit_disp_lines,
  input  logic [NUM_RS_UNITS*PARITY_W-1:0] unit_disp_paritys,
  output logic [NUM_RS_UNITS-1:0]          disp_unit_line_rdys,
  output logic                             disp_dst_line_val,
  output logic [DATA_W-1:0]                disp_dst_line,
  output logic [PARITY_W-1:0]              disp_dst_parity,
  output logic                             disp_dst_blk_end,
  output logic                             disp_dst_strm_last,
`ifdef RS_DISPATCH_STATS_EN
  output logic [31:0]                      stat_blocks,
  output logic [31:0]                      stat_pad_lines,
`endif
  input  logic                             dst_disp_line_rdy
);

  localparam int unsigned PTR_W  = cnt_w(NUM_RS_UNITS - 1);
  localparam int unsigned LCNT_W = cnt_w(NUM_LINES - 1);
  localparam int unsigned INF_W  = cnt_w(NUM_RS_UNITS);
  localparam logic [LCNT_W-1:0] LAST_LINE = LCNT_W'(NUM_LINES - 1);
  localparam logic [INF_W-1:0]  NUM_U     = INF_W'(NUM_RS_UNITS);
  localparam logic [0:0] ST_FEED = DISP_FEED;
  localparam logic [0:0] ST_PAD  = DISP_PAD;

  logic [0:0]              r_state;
  logic                    r_run;
  logic [LCNT_W-1:0]       r_in_cnt;
  logic [LCNT_W-1:0]       r_out_cnt;
  logic [INF_W-1:0]        r_inflight;
  logic [NUM_RS_UNITS-1:0] r_strm_flags;
  logic [PTR_W-1:0]        w_in_sel;
  logic [PTR_W-1:0]        w_out_sel;

  logic [0:0]        w_state_nxt;
  logic              w_gate;
  logic              w_unit_val;
  logic              w_src_rdy;
  logic [DATA_W-1:0] w_unit_line;
  logic              w_in_hs;
  logic              w_blk_done;
  logic              w_pad_enter;
  logic              w_out_q;
  logic              w_dst_val;
  logic              w_out_rdy;
  logic              w_out_hs;
  logic              w_retire;

  // Input side: feed/pad selection and block-completion detection.
  always_comb begin
    w_state_nxt = r_state;
    w_unit_val  = 1'b0;
    w_src_rdy   = 1'b0;
    w_unit_line = '0;
    w_gate      = (r_in_cnt != '0) || (r_inflight < NUM_U);
    case (r_state)
      ST_FEED: begin
        w_unit_val  = src_disp_line_val & w_gate & r_run;
        w_src_rdy   = unit_disp_line_rdys[w_in_sel] & w_gate & r_run;
        w_unit_line = src_disp_line;
      end
      ST_PAD: begin
        w_unit_val = r_run;
      end
      default: w_state_nxt = ST_FEED;
    endcase
    w_in_hs     = w_unit_val & unit_disp_line_rdys[w_in_sel];
    w_blk_done  = w_in_hs & (r_in_cnt == LAST_LINE);
    w_pad_enter = w_in_hs & (r_state == ST_FEED) & src_disp_line_last &
                  (r_in_cnt != LAST_LINE);
    if (w_pad_enter) begin
      w_state_nxt = ST_PAD;
    end else if (w_blk_done && (r_state == ST_PAD)) begin
      w_state_nxt = ST_FEED;
    end
  end

  // Output side: only a dispatched (or partly retired) block may drain.
  always_comb begin
    w_out_q   = (r_inflight != '0) || (r_out_cnt != '0);
    w_dst_val = unit_disp_line_vals[w_out_sel] & w_out_q & r_run;
    w_out_rdy = dst_disp_line_rdy & w_out_q & r_run;
    w_out_hs  = w_dst_val & dst_disp_line_rdy;
    w_retire  = w_out_hs & (r_out_cnt == LAST_LINE);
  end

  assign disp_src_line_rdy   = w_src_rdy;
  assign disp_unit_line_vals = NUM_RS_UNITS'(w_unit_val) << w_in_sel;
  assign disp_unit_line      = w_unit_line;
  assign disp_unit_line_rdys = NUM_RS_UNITS'(w_out_rdy) << w_out_sel;
  assign disp_dst_line_val   = w_dst_val;
  assign disp_dst_line       = unit_disp_lines[w_out_sel*DATA_W +: DATA_W];
  assign disp_dst_parity     = unit_disp_paritys[w_out_sel*PARITY_W +: PARITY_W];
  assign disp_dst_blk_end    = (r_out_cnt == LAST_LINE);
  assign disp_dst_strm_last  = disp_dst_blk_end & r_strm_flags[w_out_sel];

  rs_encode_rr_ptr #(.N(NUM_RS_UNITS), .W(PTR_W)) u_in_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_adv (w_blk_done),
    .o_ptr (w_in_sel)
  );

  rs_encode_rr_ptr #(.N(NUM_RS_UNITS), .W(PTR_W)) u_out_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_adv (w_retire),
    .o_ptr (w_out_sel)
  );

  // r_run holds every valid/ready low until the first clock after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_FEED;
      r_run        <= 1'b0;
      r_in_cnt     <= '0;
      r_out_cnt    <= '0;
      r_inflight   <= '0;
      r_strm_flags <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_run   <= 1'b1;
      if (w_in_hs) begin
        r_in_cnt <= w_blk_done ? '0 : r_in_cnt + 1'b1;
      end
      if (w_out_hs) begin
        r_out_cnt <= w_retire ? '0 : r_out_cnt + 1'b1;
      end
      case ({w_blk_done, w_retire})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
      // A new block's flag write takes priority over clearing the retiring one.
      if (w_retire) begin
        r_strm_flags[w_out_sel] <= 1'b0;
      end
      if (w_pad_enter) begin
        r_strm_flags[w_in_sel] <= 1'b1;
      end else if (w_blk_done && (r_state == ST_FEED)) begin
        r_strm_flags[w_in_sel] <= src_disp_line_last;
      end
    end
  end

`ifdef RS_DISPATCH_STATS_EN
  logic [31:0] r_stat_blocks;
  logic [31:0] r_stat_pad_lines;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat_blocks    <= '0;
      r_stat_pad_lines <= '0;
    end else begin
      if (w_retire && (r_stat_blocks != '1)) begin
        r_stat_blocks <= r_stat_blocks + 32'd1;
      end
      if (w_in_hs && (r_state == ST_PAD) && (r_stat_pad_lines != '1)) begin
        r_stat_pad_lines <= r_stat_pad_lines + 32'd1;
      end
    end
  end

  assign stat_blocks    = r_stat_blocks;
  assign stat_pad_lines = r_stat_pad_lines;
`endif

endmodule

// File: tb/tb_rs_encode_line_dispatch.sv
// Scoreboard bench for rs_encode_line_dispatch with a queue-based encoder-unit model.
module tb_rs_encode_line_dispatch;

  localparam int unsigned DW = 512;
  localparam int unsigned NL = 4;
  localparam int unsigned PW = 256;
  localparam int unsigned NU = 3;
  localparam int TO = 200;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             src_disp_line_val;
  logic [DW-1:0]    src_disp_line;
  logic             src_disp_line_last;
  logic             disp_src_line_rdy;
  logic [NU-1:0]    disp_unit_line_vals;
  logic [DW-1:0]    disp_unit_line;
  logic [NU-1:0]    unit_disp_line_rdys;
  logic [NU-1:0]    unit_disp_line_vals;
  logic [NU*DW-1:0] unit_disp_lines;
  logic [NU*PW-1:0] unit_disp_paritys;
  logic [NU-1:0]    disp_unit_line_rdys;
  logic             disp_dst_line_val;
  logic [DW-1:0]    disp_dst_line;
  logic [PW-1:0]    disp_dst_parity;
  logic             disp_dst_blk_end;
  logic             disp_dst_strm_last;
  logic             dst_disp_line_rdy;
`ifdef RS_DISPATCH_STATS_EN
  logic [31:0]      stat_blocks;
  logic [31:0]      stat_pad_lines;
`endif

  rs_encode_line_dispatch #(.DATA_W(DW), .NUM_LINES(NL), .PARITY_W(PW), .NUM_RS_UNITS(NU)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .src_disp_line_val   (src_disp_line_val),
    .src_disp_line       (src_disp_line),
    .src_disp_line_last  (src_disp_line_last),
    .disp_src_line_rdy   (disp_src_line_rdy),
    .disp_unit_line_vals (disp_unit_line_vals),
    .disp_unit_line      (disp_unit_line),
    .unit_disp_line_rdys (unit_disp_line_rdys),
    .unit_disp_line_vals (unit_disp_line_vals),
    .unit_disp_lines     (unit_disp_lines),
    .unit_disp_paritys   (unit_disp_paritys),
    .disp_unit_line_rdys (disp_unit_line_rdys),
    .disp_dst_line_val   (disp_dst_line_val),
    .disp_dst_line       (disp_dst_line),
    .disp_dst_parity     (disp_dst_parity),
    .disp_dst_blk_end    (disp_dst_blk_end),
    .disp_dst_strm_last  (disp_dst_strm_last),
`ifdef RS_DISPATCH_STATS_EN
    .stat_blocks         (stat_blocks),
    .stat_pad_lines      (stat_pad_lines),
`endif
    .dst_disp_line_rdy   (dst_disp_line_rdy)
  );

  always #5 clk = ~clk;

  typedef struct { int unit; logic [DW-1:0] line; } uexp_t;
  typedef struct { logic [DW-1:0] line; logic blk_end; logic strm_last; logic [PW-1:0] parity; } oexp_t;

  uexp_t uq[$];
  oexp_t oq[$];
  uexp_t mu_e;
  oexp_t mo_e;
  int errors = 0;
  int checks = 0;

  int d_sel, d_cnt;
  logic [PW-1:0] d_acc;

  function automatic logic [DW-1:0] mk(input int i);
    return {16{32'(32'hA500_0000 + i)}};
  endfunction

  function automatic logic [PW-1:0] fold(input logic [DW-1:0] l);
    return l[PW-1:0] ^ l[DW-1:PW];
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Encoder unit model: per-unit line FIFO, parity = XOR-fold of the block on its last line.
  logic [DW-1:0] um_line [NU][16];
  logic [PW-1:0] um_par  [NU][16];
  logic [PW-1:0] um_acc  [NU];
  int            um_wr [NU];
  int            um_rd [NU];
  int            um_cnt[NU];
  logic [NU-1:0] force_val;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NU; i++) begin
        um_wr[i] <= 0; um_rd[i] <= 0; um_cnt[i] <= 0; um_acc[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NU; i++) begin
        if (disp_unit_line_vals[i] && unit_disp_line_rdys[i]) begin
          um_line[i][um_wr[i] % 16] <= disp_unit_line;
          um_par[i][um_wr[i] % 16]  <= (um_cnt[i] == NL - 1) ? (um_acc[i] ^ fold(disp_unit_line)) : '0;
          um_acc[i] <= (um_cnt[i] == NL - 1) ? '0 : (um_acc[i] ^ fold(disp_unit_line));
          um_cnt[i] <= (um_cnt[i] == NL - 1) ? 0 : um_cnt[i] + 1;
          um_wr[i]  <= um_wr[i] + 1;
        end
        if (unit_disp_line_vals[i] && disp_unit_line_rdys[i] && (um_wr[i] != um_rd[i]))
          um_rd[i] <= um_rd[i] + 1;
      end
    end
  end

  for (genvar g = 0; g < NU; g++) begin : g_unit
    assign unit_disp_line_vals[g]          = (um_wr[g] != um_rd[g]) | force_val[g];
    assign unit_disp_lines[g*DW +: DW]     = um_line[g][um_rd[g] % 16];
    assign unit_disp_paritys[g*PW +: PW]   = um_par[g][um_rd[g] % 16];
  end

  // Monitor: lines entering the units.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < NU; i++) begin
        if (disp_unit_line_vals[i] && unit_disp_line_rdys[i]) begin
          if (uq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unit_unexpected: unit %0d got line %0h with nothing expected", i, disp_unit_line);
          end else begin
            mu_e = uq.pop_front();
            chk("unit_sel", DW'(i), DW'(mu_e.unit));
            chk("unit_line", disp_unit_line, mu_e.line);
          end
        end
      end
    end
  end

  // Monitor: lines leaving to the destination.
  always @(negedge clk) begin
    if (rst_n && disp_dst_line_val && dst_disp_line_rdy) begin
      if (oq.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: line %0h with nothing expected", disp_dst_line);
      end else begin
        mo_e = oq.pop_front();
        chk("out_line", disp_dst_line, mo_e.line);
        chk("out_blk_end", DW'(disp_dst_blk_end), DW'(mo_e.blk_end));
        chk("out_strm_last", DW'(disp_dst_strm_last), DW'(mo_e.strm_last));
        if (mo_e.blk_end) chk("out_parity", DW'(disp_dst_parity), DW'(mo_e.parity));
      end
    end
  end

  task automatic expect_line(input logic [DW-1:0] l, input bit strm);
    uexp_t u;
    oexp_t o;
    u.unit = d_sel; u.line = l;
    uq.push_back(u);
    d_acc = d_acc ^ fold(l);
    o.line = l; o.blk_end = (d_cnt == NL - 1); o.strm_last = (d_cnt == NL - 1) && strm; o.parity = d_acc;
    oq.push_back(o);
    if (d_cnt == NL - 1) begin
      d_cnt = 0; d_acc = '0; d_sel = (d_sel + 1) % NU;
    end else begin
      d_cnt++;
    end
  endtask

  task automatic drive_line(input logic [DW-1:0] l, input bit last, input int exp_first);
    int n;
    bit hs;
    expect_line(l, last);
    if (last) while (d_cnt != 0) expect_line('0, 1'b1);
    src_disp_line_val = 1'b1; src_disp_line = l; src_disp_line_last = last;
    n = 0; hs = 1'b0;
    while (!hs && n < TO) begin
      @(negedge clk);
      if (n == 0 && exp_first >= 0) chk("src_rdy_first", DW'(disp_src_line_rdy), DW'(exp_first));
      hs = disp_src_line_rdy;
      n++;
    end
    if (!hs) begin
      checks++; errors++;
      $display("FAIL src_timeout: line %0h not accepted in %0d cycles", l, TO);
    end
    @(posedge clk); #1;
    src_disp_line_val = 1'b0; src_disp_line_last = 1'b0;
  endtask

  task automatic send_block(input int base, input int n, input bit last_at_end);
    for (int i = 0; i < n; i++) drive_line(mk(base + i), last_at_end && (i == n - 1), -1);
  endtask

  task automatic check_stall(input logic [DW-1:0] l, input int n);
    src_disp_line_val = 1'b1; src_disp_line = l; src_disp_line_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("stall_rdy", DW'(disp_src_line_rdy), DW'(0));
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((oq.size() != 0 || uq.size() != 0) && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("drain_left", DW'(oq.size() + uq.size()), DW'(0));
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    oq.delete(); uq.delete();
    d_sel = 0; d_cnt = 0; d_acc = '0;
    src_disp_line_val = 1'b0; src_disp_line_last = 1'b0; src_disp_line = '0;
    dst_disp_line_rdy = 1'b1; unit_disp_line_rdys = '1; force_val = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state with all external readies high.
    rst_n = 1'b0;
    d_sel = 0; d_cnt = 0; d_acc = '0;
    src_disp_line_val = 1'b1; src_disp_line_last = 1'b0; src_disp_line = mk(0);
    dst_disp_line_rdy = 1'b1; unit_disp_line_rdys = '1; force_val = '0;
    #1;
    chk("rst_src_rdy", DW'(disp_src_line_rdy), DW'(0));
    chk("rst_unit_vals", DW'(disp_unit_line_vals), DW'(0));
    chk("rst_unit_rdys", DW'(disp_unit_line_rdys), DW'(0));
    chk("rst_dst_val", DW'(disp_dst_line_val), DW'(0));

    // Six blocks round-robin over three units, stream last on line 23.
    do_reset();
    send_block(0, 24, 1'b1);
    drain();

    // Four blocks; once all retired, a stray unit1 valid must not leak out.
    do_reset();
    send_block(100, 16, 1'b1);
    drain();
    force_val = 3'b010;
    repeat (4) begin
      @(negedge clk);
      chk("idle_dst_val", DW'(disp_dst_line_val), DW'(0));
      chk("idle_unit_rdys", DW'(disp_unit_line_rdys), DW'(0));
    end
    @(posedge clk); #1 force_val = '0;

    // Short final block: last on line 1, two pad lines follow.
    do_reset();
    drive_line(mk(200), 1'b0, -1);
    drive_line(mk(201), 1'b1, -1);
    repeat (2) begin
      @(negedge clk);
      chk("pad_src_rdy", DW'(disp_src_line_rdy), DW'(0));
      chk("pad_unit_vals", DW'(disp_unit_line_vals), DW'(1));
    end
    @(negedge clk);
    chk("post_pad_src_rdy", DW'(disp_src_line_rdy), DW'(1));
    drain();
`ifdef RS_DISPATCH_STATS_EN
    chk("stat_pad_lines", DW'(stat_pad_lines), DW'(2));
    chk("stat_blocks", DW'(stat_blocks), DW'(1));
`endif

    // All units loaded: fourth block stalls until exactly one retire.
    do_reset();
    dst_disp_line_rdy = 1'b0;
    send_block(300, 12, 1'b0);
    check_stall(mk(312), 3);
    fork
      send_block(312, 4, 1'b0);
      begin
        dst_disp_line_rdy = 1'b1;
        repeat (4) @(posedge clk);
        #1 dst_disp_line_rdy = 1'b0;
      end
    join
    check_stall(mk(316), 3);
    dst_disp_line_rdy = 1'b1;
    send_block(316, 4, 1'b1);
    drain();

    // Dispatch completion and retire in the same cycle leave inflight unchanged.
    do_reset();
    dst_disp_line_rdy = 1'b0;
    send_block(400, 11, 1'b0);
    dst_disp_line_rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    drive_line(mk(411), 1'b0, 1);
    dst_disp_line_rdy = 1'b0;
    drive_line(mk(412), 1'b0, 1);
    send_block(413, 3, 1'b0);
    check_stall(mk(416), 3);
    dst_disp_line_rdy = 1'b1;
    send_block(416, 4, 1'b1);
    drain();

    // Asynchronous reset while padding is stalled.
    do_reset();
    drive_line(mk(500), 1'b1, -1);
    unit_disp_line_rdys = '0;
    @(negedge clk);
    chk("pad_hold_vals", DW'(disp_unit_line_vals), DW'(1));
    chk("pad_hold_src_rdy", DW'(disp_src_line_rdy), DW'(0));
    #2;
    unit_disp_line_rdys = '1;
    rst_n = 1'b0;
    oq.delete(); uq.delete();
    d_sel = 0; d_cnt = 0; d_acc = '0;
    #1;
    chk("arst_unit_vals", DW'(disp_unit_line_vals), DW'(0));
    chk("arst_src_rdy", DW'(disp_src_line_rdy), DW'(0));
    chk("arst_unit_rdys", DW'(disp_unit_line_rdys), DW'(0));
    chk("arst_dst_val", DW'(disp_dst_line_val), DW'(0));
`ifdef RS_DISPATCH_STATS_EN
    chk("arst_stat_blocks", DW'(stat_blocks), DW'(0));
    chk("arst_stat_pad", DW'(stat_pad_lines), DW'(0));
`endif
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_block(600, 4, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
